mul_add: RTL

MUL_ADD -- requirements
Module: mul_add

---
 rtl/mul_add.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mul_add.sv
// mul_add: reconstructs a dividend from quotient, divisor and remainder
// (a = q*b + r) with a shift-and-add multiplier that retires one multiplier
// bit per cycle. The datapath is expressed as library-cell equivalents
// (FD2 flops, full adders, MUX21H selectors, AN2/OR2/IV gates). The
// transistor tally of those cells is reported on `number`.
module mul_add (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_in_valid,
  input  logic [7:0]  i_q,
  input  logic [4:0]  i_b,
  input  logic [4:0]  i_r,
  output logic        o_busy,
  output logic [12:0] o_a,
  output logic        o_ovf,
  output logic        o_err,
  output logic        o_out_valid,
  output logic [50:0] number
);

  // Per-cell transistor counts.
  localparam int unsigned Fd2Tr    = 36;
  localparam int unsigned Mux21hTr = 12;
  localparam int unsigned FaTr     = 28;
  localparam int unsigned An2Tr    = 6;
  localparam int unsigned Or2Tr    = 6;
  localparam int unsigned IvTr     = 2;

  // Cell counts: flops are state(2) acc(13) mcand(12) mplier(8) cnt(3)
  // err_cap(1) a(13) ovf(1) err(1) out_valid(1).
  localparam int unsigned NumFd2 = 2 + 13 + 12 + 8 + 3 + 1 + 13 + 1 + 1 + 1;
  // Selectors in front of every flop except state and out_valid.
  localparam int unsigned NumMux = 13 + 12 + 8 + 3 + 1 + 13 + 1 + 1;
  // Accumulator adder, counter incrementer, r >= b comparator.
  localparam int unsigned NumFa  = 13 + 3 + 5;
  // Addend gating, cnt == 7 detect, done-entry qualify.
  localparam int unsigned NumAn2 = 12 + 2 + 1;
  // OR tree over the five high sum bits.
  localparam int unsigned NumOr2 = 4;
  // Divisor inversion for the comparator.
  localparam int unsigned NumIv  = 5;

  localparam int unsigned TotalTr = NumFd2 * Fd2Tr + NumMux * Mux21hTr + NumFa * FaTr +
                                    NumAn2 * An2Tr + NumOr2 * Or2Tr + NumIv * IvTr;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        run;

  logic [12:0] acc_q, acc_d;
  logic [11:0] mcand_q, mcand_d;   // i_b shifted left once per step, 5+7 bits
  logic [7:0]  mplier_q, mplier_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_cap_q, err_cap_d;

  logic [12:0] a_q, a_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;
  logic        out_valid_q, out_valid_d;

  logic [12:0] addend;
  logic [12:0] acc_sum;
  logic [2:0]  cnt_inc;
  logic [4:0]  b_inv;
  logic        r_ge_b;
  logic        last_step;
  logic        done_entry;
  logic        sum_hi_nz;

  // State register (two FD2 cells).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE and DONE both accept a new request; RUN lasts 8 steps.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: state_d = i_in_valid ? StRun : StIdle;
      StRun:          state_d = last_step ? StDone : StRun;
      default:        state_d = StIdle;
    endcase
  end

  // FSM outputs: the datapath steps only in RUN.
  always_comb begin
    run = 1'b0;
    if (state_q == StRun) begin
      run = 1'b1;
    end
  end

  assign o_busy = run;

  // AN2 gates: partial product gating and end-of-run detection.
  always_comb begin
    addend     = {1'b0, mcand_q & {12{mplier_q[0]}}};
    last_step  = (cnt_q[0] & cnt_q[1]) & cnt_q[2];
    done_entry = run & last_step;
  end

  // IV gates feeding the comparator's subtract input.
  assign b_inv = ~i_b;

  // Ripple-carry accumulator adder: acc + gated partial product.
  always_comb begin
    logic c_acc;
    acc_sum = '0;
    c_acc   = 1'b0;
    for (int k = 0; k < 13; k++) begin
      acc_sum[k] = acc_q[k] ^ addend[k] ^ c_acc;
      c_acc      = (acc_q[k] & addend[k]) | (c_acc & (acc_q[k] ^ addend[k]));
    end
  end

  // Step counter incrementer (adder cells with b tied low, carry-in high).
  always_comb begin
    logic c_inc;
    cnt_inc = '0;
    c_inc   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cnt_inc[k] = cnt_q[k] ^ c_inc;
      c_inc      = cnt_q[k] & c_inc;
    end
  end

  // r - b via r + ~b + 1; carry-out set means r >= b (always set when b = 0).
  always_comb begin
    logic c_cmp;
    c_cmp = 1'b1;
    for (int k = 0; k < 5; k++) begin
      c_cmp = (i_r[k] & b_inv[k]) | (c_cmp & (i_r[k] ^ b_inv[k]));
    end
    r_ge_b = c_cmp;
  end

  // OR2 tree: any bit above 7 set means the result is not an 8-bit dividend.
  always_comb begin
    logic lo_pair, hi_pair;
    lo_pair   = acc_sum[8] | acc_sum[9];
    hi_pair   = acc_sum[10] | acc_sum[11];
    sum_hi_nz = (lo_pair | hi_pair) | acc_sum[12];
  end

  // MUX21H bank: operands load whenever not running, so the accept edge
  // captures them; the result registers load only on the final step.
  always_comb begin
    acc_d       = run ? acc_sum : {8'b0, i_r};
    mcand_d     = run ? {mcand_q[10:0], 1'b0} : {7'b0, i_b};
    mplier_d    = run ? {1'b0, mplier_q[7:1]} : i_q;
    cnt_d       = run ? cnt_inc : 3'd0;
    err_cap_d   = run ? err_cap_q : r_ge_b;
    a_d         = done_entry ? acc_sum : a_q;
    ovf_d       = done_entry ? sum_hi_nz : ovf_q;
    err_d       = done_entry ? err_cap_q : err_q;
    out_valid_d = done_entry;
  end

  // Datapath registers (FD2 cells).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      err_cap_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      err_cap_q <= err_cap_d;
    end
  end

  // Result registers (FD2 cells); out_valid is a registered one-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o_a         = a_q;
  assign o_ovf       = ovf_q;
  assign o_err       = err_q;
  assign o_out_valid = out_valid_q;
  assign number      = 51'(TotalTr);

endmodule
